alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Pipeline stage directly downstream of the ALU. Captures r_o/flags_o plus the
//  destination tag into a 2-entry skid buffer with valid/ready handshakes toward
//  writeback, and owns the architectural status register (C,V,Z,N).
//  Evaluates a 4-bit condition code against the status register for branch logic.
// PARAMETERS
//  AW         3        destination register address width
//  INIT_FLAGS 4'b0000  reset value of status register {C,V,Z,N}
//  (data width N and types funcALU/flagsALU come from package pico)
// PORTS
//  clk_i       in   1        clock, all state on rising edge
//  rst_i       in   1        reset, asynchronous, active-high
//  valid_i     in   1        ALU result present this cycle
//  ready_o     out  1        stage can accept; transfer when valid_i & ready_o
//  r_i         in   N        ALU result (alu r_o)
//  flags_i     in   flagsALU ALU flags (alu flags_o)
//  op_i        in   funcALU  operation that produced r_i
//  dst_i       in   AW       destination register
//  we_i        in   1        result is to be written back
//  valid_o     out  1        entry available to writeback
//  ready_i     in   1        writeback accepts; transfer when valid_o & ready_i
//  r_o         out  N        buffered result
//  dst_o       out  AW       buffered destination
//  we_o        out  1        buffered write enable
//  status_o    out  flagsALU architectural status register
//  flag_upd_o  out  1        1-cycle pulse: status register updated last edge
//  cond_i      in   4        condition code to evaluate
//  cond_true_o out  1        condition result (combinational)
// BEHAVIOUR
//  Reset: valid_o=0, ready_o=1, r_o/dst_o/we_o=0, status_o=INIT_FLAGS,
//   flag_upd_o=0; skid entry invalid. Reset mid-transfer discards both entries.
//  Skid buffer: main reg (drives outputs) + skid reg. ready_o = ~skid_valid,
//   registered (no comb path ready_i->ready_o).
//  Accept with main empty, or main draining (ready_i) and skid empty -> main,
//   valid_o=1 next cycle. Latency input->output: 1 cycle.
//  Accept while main full and not draining -> skid; ready_o=0 next cycle.
//  Drain with skid valid -> skid moves to main, skid_valid=0, ready_o=1 next.
//  Simultaneous accept+drain when full: impossible (ready_o=0); no data loss or
//   duplication in any combination; order strictly preserved.
//  Holding: while valid_o & ~ready_i, r_o/dst_o/we_o stable.
//  Status update at acceptance edge (in program order), per op_i:
//   F_ADD,F_SUB: C,V,Z,N <= flags_i
//   F_AND,F_OR,F_XOR,F_NOT,F_MUL: Z,N <= flags_i; C,V retained
//   F_A, others: no update
//  Z for logic ops recomputed here as ~|r_i (ALU Z reflects adder path only).
//  flag_upd_o=1 the cycle after any updating acceptance.
//  cond_i: 0 AL,1 EQ Z,2 NE ~Z,3 CS C,4 CC ~C,5 MI N,6 PL ~N,7 VS V,8 VC ~V,
//   9 HI C&~Z,10 LS ~C|Z,11 GE N==V,12 LT N!=V,13 GT ~Z&(N==V),
//   14 LE Z|(N!=V),15 NV 0.
// CONFIGURATION
//  PICO_FLAG_BYPASS_EN defined: cond_true_o evaluated on next-status value
//   (flags being written by an updating acceptance this cycle are forwarded).
//  Not defined: cond_true_o uses registered status_o only (1-cycle flag latency).
// TESTING
//  Reset -> valid_o=0, ready_o=1, status_o=INIT_FLAGS, cond 0 -> 1, cond 15 -> 0.
//  F_ADD r=8'h00 flags C=1,Z=1 accepted, ready_i=1 -> next cycle valid_o=1,
//   r_o=0, status C=1,Z=1, flag_upd_o=1; cond 1 (EQ) -> 1.
//  ready_i=0, send 3 results A,B,C back-to-back -> A in main, B in skid,
//   ready_o=0, C held by source; ready_i=1 -> outputs A,B,C in order, no gaps lost.
//  After F_SUB sets C=1,V=1, F_AND r=8'h80 -> C=1,V=1 kept, Z=0,N=1;
//   cond 12 (LT) -> 0, cond 9 (HI) -> 1. Then F_A -> flag_upd_o=0, status unchanged.
//  rst_i asserted mid-stream with 2 entries buffered -> valid_o=0, ready_o=1
//   immediately (async), no stale entry output after release.
//  Bypass: F_SUB Z=1 accepted with cond_i=1 same cycle -> cond_true_o=1 with
//   PICO_FLAG_BYPASS_EN, =old Z without.

Source files
------------

// File: rtl/pico.sv
// pico: shared ALU data width, operation encoding and flag layout
package pico;
  localparam int N = 8;
  typedef enum logic [3:0] {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOT, F_MUL, F_A, F_SHL, F_SHR} funcALU;
  typedef struct packed {logic c; logic v; logic z; logic n;} flagsALU;
endpackage

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid buffer after the ALU, status register {C,V,Z,N} and condition evaluation
// Ports: clk_i/rst_i (async active-high reset); valid_i/ready_o + r_i/flags_i/op_i/dst_i/we_i from the ALU;
//   valid_o/ready_i + r_o/dst_o/we_o toward writeback; status_o, flag_upd_o; cond_i -> cond_true_o.
// Config macro PICO_FLAG_BYPASS_EN: condition evaluated on the status being written this cycle.
module alu_result_stage
  import pico::*;
#(
  parameter int      AW         = 3,
  parameter flagsALU INIT_FLAGS = 4'b0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [N-1:0]  r_i,
  input  flagsALU       flags_i,
  input  funcALU        op_i,
  input  logic [AW-1:0] dst_i,
  input  logic          we_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [N-1:0]  r_o,
  output logic [AW-1:0] dst_o,
  output logic          we_o,
  output flagsALU       status_o,
  output logic          flag_upd_o,
  input  logic [3:0]    cond_i,
  output logic          cond_true_o
);
  typedef struct packed {
    logic [N-1:0]  r;
    logic [AW-1:0] dst;
    logic          we;
  } entry_t;
  entry_t  main_q, main_d, skid_q, skid_d, in_e;
  logic    main_v_q, main_v_d, skid_v_q, skid_v_d;
  flagsALU status_q, status_d, eval_f;
  logic    upd_q, upd_d, acc, drn, arith, logic_op;
  function automatic logic eval_cond(input flagsALU f, input logic [3:0] c);
    case (c)
      4'd0:    return 1'b1;
      4'd1:    return f.z;
      4'd2:    return ~f.z;
      4'd3:    return f.c;
      4'd4:    return ~f.c;
      4'd5:    return f.n;
      4'd6:    return ~f.n;
      4'd7:    return f.v;
      4'd8:    return ~f.v;
      4'd9:    return f.c & ~f.z;
      4'd10:   return ~f.c | f.z;
      4'd11:   return f.n == f.v;
      4'd12:   return f.n != f.v;
      4'd13:   return ~f.z & (f.n == f.v);
      4'd14:   return f.z | (f.n != f.v);
      default: return 1'b0;
    endcase
  endfunction
  // ready_o comes straight from a flop, so there is no ready_i -> ready_o path
  assign ready_o = ~skid_v_q;
  assign valid_o = main_v_q;
  assign r_o     = main_q.r;
  assign dst_o   = main_q.dst;
  assign we_o    = main_q.we;
  assign status_o   = status_q;
  assign flag_upd_o = upd_q;
  always_comb begin
    acc      = valid_i & ready_o;
    drn      = main_v_q & ready_i;
    in_e     = '{r: r_i, dst: dst_i, we: we_i};
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    // skid full implies ready_o=0, so no accept can coincide with the skid->main move
    if (drn & skid_v_q) begin
      main_d   = skid_q;
      skid_v_d = 1'b0;
    end else if (drn | ~main_v_q) begin
      main_v_d = acc;
      main_d   = acc ? in_e : main_q;
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d   = in_e;
    end
  end
  // ALU Z only tracks the adder, so logic/mul ops get Z from the result itself
  always_comb begin
    arith    = op_i inside {F_ADD, F_SUB};
    logic_op = op_i inside {F_AND, F_OR, F_XOR, F_NOT, F_MUL};
    upd_d    = acc & (arith | logic_op);
    status_d = ~upd_d ? status_q
             : arith  ? flags_i
             :          flagsALU'({status_q.c, status_q.v, ~|r_i, flags_i.n});
  end
`ifdef PICO_FLAG_BYPASS_EN
  assign eval_f = status_d;
`else
  assign eval_f = status_q;
`endif
  assign cond_true_o = eval_cond(eval_f, cond_i);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      status_q <= INIT_FLAGS;
      upd_q    <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      status_q <= status_d;
      upd_q    <= upd_d;
    end
  end
endmodule
